uart_mem_bridge: RTL

Host-command engine sitting directly behind uart_comm.
- Pops bytes from uart_comm's receive FIFO and parses framed read/write commands.
- Issues 32-bit transactions on the RISC-V memory bus.
- Pushes acknowledge/readback bytes into uart_comm's send FIFO.
- Lets a host PC load program memory and inspect state over the serial link.

---
 rtl/uart_bridge_pkg.sv | 26 ++
 rtl/uart_byte_shift.sv | 42 ++++
 rtl/uart_mem_bridge.sv | 186 ++++++++++++++++++
 3 files changed

// File: rtl/uart_bridge_pkg.sv
// Shared constants and state encoding for the UART-to-memory command bridge.
package uart_bridge_pkg;

  // Host command opcodes (first byte of every frame).
  localparam logic [7:0] OP_WRITE  = 8'h01;
  localparam logic [7:0] OP_READ   = 8'h02;

  // Response bytes pushed back to the host.
  localparam logic [7:0] RSP_ACK   = 8'hA5;
  localparam logic [7:0] RSP_RDATA = 8'h5A;
  localparam logic [7:0] RSP_ERR   = 8'hEE;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_ADDR = 3'd1,
    ST_DATA = 3'd2,
    ST_MEM  = 3'd3,
    ST_RESP = 3'd4
  } state_t;

  // Increment that sticks once the limit is reached.
  function automatic logic [7:0] sat_inc(input logic [7:0] value, input logic [7:0] limit);
    return (value >= limit) ? value : value + 8'd1;
  endfunction

endpackage

// File: rtl/uart_byte_shift.sv
// Four-byte little-endian assembler/disassembler. Bytes are written into (or
// read out of) the word one lane at a time, lane selected by a 2-bit index.
module uart_byte_shift (
  input  logic        CLK,
  input  logic        RST,
  input  logic        clear,
  input  logic        wr_en,
  input  logic [7:0]  byte_in,
  input  logic        load,
  input  logic [31:0] word_in,
  input  logic        rd_en,
  output logic [31:0] word,
  output logic [7:0]  byte_out,
  output logic        last
);

  logic [1:0] idx;

  // Lane index and word storage; a parallel load wins over clear, clear over a byte step.
  always_ff @(posedge CLK) begin
    // NOTE: sequential state is always assigned with <= so every flop samples pre-edge values.
    if (RST) begin
      idx  <= 2'd0;
      // NOTE: word is a handful of flops, not a RAM, so resetting it is cheap and keeps outputs defined.
      word <= 32'd0;
    end else if (load) begin
      word <= word_in;
      idx  <= 2'd0;
    end else if (clear) begin
      idx  <= 2'd0;
    end else if (wr_en) begin
      word[{idx, 3'b000} +: 8] <= byte_in;
      idx                      <= idx + 2'd1;
    end else if (rd_en) begin
      idx <= idx + 2'd1;
    end
  end

  assign byte_out = word[{idx, 3'b000} +: 8];
  assign last     = (idx == 2'd3);

endmodule

// File: rtl/uart_mem_bridge.sv
// Host-command engine behind uart_comm: parses framed read/write commands from
// the receive FIFO, runs one 32-bit bus transaction per frame and pushes the
// acknowledge/readback bytes into the send FIFO.
module uart_mem_bridge
  import uart_bridge_pkg::*;
#(
  parameter int TIMEOUT = 1000000,
  parameter int ERR_SAT = 255
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        receivable,
  input  logic [7:0]  recv_data,
  output logic        recv_flag,
  input  logic        sendable,
  output logic        send_flag,
  output logic [7:0]  send_data,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ready,
  output logic        busy,
  output logic [7:0]  err_count
);

  localparam int             TW     = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [TW-1:0]  T_LAST = TW'(TIMEOUT - 1);
  localparam logic [7:0]     SAT    = 8'(ERR_SAT);

  state_t        state;
  logic          op_write;
  logic [TW-1:0] tcnt;
  logic [7:0]    resp_tag;
  logic          resp_multi;
  logic [2:0]    resp_cnt;

  logic          frame_clr, addr_wr, data_wr, data_load, data_rd, push;
  logic [31:0]   addr_word, data_word;
  logic [7:0]    data_byte, addr_byte_unused;
  logic          addr_last, data_last;

  // Address assembler: filled byte by byte in ADDR, never read out bytewise.
  uart_byte_shift u_addr (
    .CLK      (CLK),
    .RST      (RST),
    .clear    (frame_clr),
    .wr_en    (addr_wr),
    .byte_in  (recv_data),
    .load     (1'b0),
    .word_in  (32'd0),
    .rd_en    (1'b0),
    .word     (addr_word),
    .byte_out (addr_byte_unused),
    .last     (addr_last)
  );

  // Data assembler: write data in DATA, then reloaded with read data and drained in RESP.
  uart_byte_shift u_data (
    .CLK      (CLK),
    .RST      (RST),
    .clear    (frame_clr),
    .wr_en    (data_wr),
    .byte_in  (recv_data),
    .load     (data_load),
    .word_in  (mem_rdata),
    .rd_en    (data_rd),
    .word     (data_word),
    .byte_out (data_byte),
    .last     (data_last)
  );

  // Per-cycle strobes for the byte assemblers and the send-side push decision.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can leave one unassigned and infer a latch.
    frame_clr = 1'b0;
    addr_wr   = 1'b0;
    data_wr   = 1'b0;
    data_load = 1'b0;
    data_rd   = 1'b0;
    push      = 1'b0;
    case (state)
      ST_IDLE: frame_clr = recv_flag;
      ST_ADDR: addr_wr   = recv_flag;
      ST_DATA: data_wr   = recv_flag;
      ST_MEM:  data_load = mem_ready && !mem_we;
      ST_RESP: begin
        push    = sendable && !send_flag;
        data_rd = push && (resp_cnt != 3'd0);
      end
      default: ;
    endcase
  end

  // Frame parser, inter-byte timeout, bus handshake and response sequencer.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state      <= ST_IDLE;
      recv_flag  <= 1'b0;
      send_flag  <= 1'b0;
      send_data  <= 8'd0;
      mem_req    <= 1'b0;
      mem_we     <= 1'b0;
      err_count  <= 8'd0;
      op_write   <= 1'b0;
      tcnt       <= '0;
      resp_tag   <= 8'd0;
      resp_multi <= 1'b0;
      resp_cnt   <= 3'd0;
    end else begin
      // Pops and pushes are single-cycle pulses; the cycle after one is always idle.
      recv_flag <= 1'b0;
      send_flag <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (recv_flag) begin
            tcnt <= '0;
            if (recv_data == OP_WRITE || recv_data == OP_READ) begin
              op_write <= (recv_data == OP_WRITE);
              state    <= ST_ADDR;
            end else begin
              resp_tag   <= RSP_ERR;
              resp_multi <= 1'b0;
              resp_cnt   <= 3'd0;
              err_count  <= sat_inc(err_count, SAT);
              state      <= ST_RESP;
            end
          end else begin
            recv_flag <= receivable;
          end
        end
        ST_ADDR, ST_DATA: begin
          if (recv_flag) begin
            tcnt <= '0;
            if (state == ST_ADDR && addr_last && op_write) begin
              state <= ST_DATA;
            end else if ((state == ST_ADDR && addr_last) || (state == ST_DATA && data_last)) begin
              // A0 is already stored, so alignment is known when the last byte lands.
              if (addr_word[1:0] == 2'b00) begin
                mem_req <= 1'b1;
                mem_we  <= (state == ST_DATA);
                state   <= ST_MEM;
              end else begin
                resp_tag   <= RSP_ERR;
                resp_multi <= 1'b0;
                resp_cnt   <= 3'd0;
                err_count  <= sat_inc(err_count, SAT);
                state      <= ST_RESP;
              end
            end
          end else if (tcnt == T_LAST) begin
            err_count <= sat_inc(err_count, SAT);
            state     <= ST_IDLE;
          end else begin
            tcnt      <= tcnt + 1'b1;
            recv_flag <= receivable;
          end
        end
        ST_MEM: begin
          if (mem_ready) begin
            mem_req    <= 1'b0;
            resp_tag   <= mem_we ? RSP_ACK : RSP_RDATA;
            resp_multi <= !mem_we;
            resp_cnt   <= 3'd0;
            state      <= ST_RESP;
          end
        end
        ST_RESP: begin
          if (push) begin
            send_flag <= 1'b1;
            send_data <= (resp_cnt == 3'd0) ? resp_tag : data_byte;
            resp_cnt  <= resp_cnt + 3'd1;
            if (!resp_multi || resp_cnt == 3'd4) state <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign busy      = (state != ST_IDLE);
  assign mem_addr  = {addr_word[31:2], 2'b00};
  assign mem_wdata = data_word;

endmodule
